// File: rtl/if_fetch_ctrl_if.sv
// Instruction-memory read bus between the fetch controller and imem.
// The master raises imem_req with a stable imem_addr until imem_ack pulses;
// imem_rdata is only meaningful in the ack cycle.
interface if_fetch_ctrl_if #(
    parameter int DATA_W = 32
);
    logic              imem_req;
    logic [31:0]       imem_addr;
    logic              imem_ack;
    logic [DATA_W-1:0] imem_rdata;

    modport master (
        output imem_req,
        output imem_addr,
        input  imem_ack,
        input  imem_rdata
    );

    modport slave (
        input  imem_req,
        input  imem_addr,
        output imem_ack,
        output imem_rdata
    );
endinterface

// File: rtl/if_fetch_ctrl.sv
// Instruction-fetch controller.
// Reads the PC register output, drives its next value/enable, runs the
// req/ack imem read and hands fetched words to the IF/ID boundary through a
// one-entry skid buffer. Branch redirects flush the IF/ID slot and the skid;
// a request already in flight at a redirect is completed and its data dropped.
module if_fetch_ctrl #(
    parameter logic [31:0] RESET_VECTOR = 32'h0000_0000,
    parameter int          DATA_W       = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [31:0]       i_pc_in,
    output logic [31:0]       o_pc_next,
    output logic              o_pc_en,
    if_fetch_ctrl_if.master   imem,
    input  logic              i_branch_taken,
    input  logic [31:0]       i_branch_target,
    input  logic              i_stall_id,
    output logic [DATA_W-1:0] o_if_id_instr,
    output logic [31:0]       o_if_id_pc4,
    output logic              o_if_id_valid
);

    typedef enum logic [2:0] {
        S_INIT  = 3'd0,
        S_ISSUE = 3'd1,
        S_WAIT  = 3'd2,
        S_SKID  = 3'd3,
        S_FLUSH = 3'd4
    } state_t;

    state_t            r_state;
    logic [31:0]       r_addr_q;
    logic              r_if_id_valid;
    logic [DATA_W-1:0] r_if_id_instr;
    logic [31:0]       r_if_id_pc4;
    logic              r_skid_valid;
    logic [DATA_W-1:0] r_skid_instr;
    logic [31:0]       r_skid_pc4;

    state_t            w_state_next;
    logic [31:0]       w_fetch_addr;
    logic [31:0]       w_fetch_pc4;
    logic              w_slot_free;
    logic              w_pc_en;
    logic [31:0]       w_pc_next;
    logic              w_req;
    logic [31:0]       w_addr;
    logic              w_capture_addr;
    logic              w_flush_slots;
    logic              w_load_if_id;
    logic              w_drain_skid;
    logic              w_load_skid;

    // In ISSUE the address comes straight from the PC; afterwards it is held in addr_q.
    assign w_fetch_addr = (r_state == S_ISSUE) ? i_pc_in : r_addr_q;
    assign w_fetch_pc4  = w_fetch_addr + 32'd4;
    assign w_slot_free  = !r_if_id_valid || !i_stall_id;

    // Next-state and output decode; a branch outranks ack and skid drain.
    always_comb begin
        w_state_next   = r_state;
        w_pc_en        = 1'b0;
        w_pc_next      = w_fetch_pc4;
        w_req          = 1'b0;
        w_addr         = r_addr_q;
        w_capture_addr = 1'b0;
        w_flush_slots  = 1'b0;
        w_load_if_id   = 1'b0;
        w_drain_skid   = 1'b0;
        w_load_skid    = 1'b0;

        case (r_state)
            S_INIT: begin
                // Redirects are ignored here: the PC is being seeded.
                w_pc_en      = 1'b1;
                w_pc_next    = RESET_VECTOR;
                w_state_next = S_ISSUE;
            end

            S_ISSUE, S_WAIT: begin
                w_req          = 1'b1;
                w_addr         = w_fetch_addr;
                w_capture_addr = (r_state == S_ISSUE);
                if (i_branch_taken) begin
                    w_pc_en       = 1'b1;
                    w_pc_next     = i_branch_target;
                    w_flush_slots = 1'b1;
                    // Without an ack the request is still outstanding and must be drained.
                    w_state_next  = imem.imem_ack ? S_ISSUE : S_FLUSH;
                end else if (imem.imem_ack) begin
                    w_pc_en   = 1'b1;
                    w_pc_next = w_fetch_pc4;
                    if (w_slot_free) begin
                        w_load_if_id = 1'b1;
                        w_state_next = S_ISSUE;
                    end else begin
                        w_load_skid  = 1'b1;
                        w_state_next = S_SKID;
                    end
                end else begin
                    w_state_next = S_WAIT;
                end
            end

            S_SKID: begin
                if (i_branch_taken) begin
                    w_pc_en       = 1'b1;
                    w_pc_next     = i_branch_target;
                    w_flush_slots = 1'b1;
                    w_state_next  = S_ISSUE;
                end else if (r_skid_valid && !i_stall_id) begin
                    w_drain_skid = 1'b1;
                    w_state_next = S_ISSUE;
                end
            end

            S_FLUSH: begin
                // The stale request stays on the bus until it completes.
                w_req = 1'b1;
                if (i_branch_taken) begin
                    w_pc_en       = 1'b1;
                    w_pc_next     = i_branch_target;
                    w_flush_slots = 1'b1;
                    w_state_next  = imem.imem_ack ? S_ISSUE : S_FLUSH;
                end else if (imem.imem_ack) begin
                    w_state_next = S_ISSUE;
                end
            end

            default: begin
                w_state_next = S_INIT;
            end
        endcase

        // Nothing leaves the block while reset is asserted.
        if (!rst_n) begin
            w_pc_en = 1'b0;
            w_req   = 1'b0;
        end
    end

    // State, latched fetch address, IF/ID slot and skid buffer.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state       <= S_INIT;
            r_addr_q      <= 32'd0;
            r_if_id_valid <= 1'b0;
            r_if_id_instr <= '0;
            r_if_id_pc4   <= 32'd0;
            r_skid_valid  <= 1'b0;
            r_skid_instr  <= '0;
            r_skid_pc4    <= 32'd0;
        end else begin
            r_state <= w_state_next;
            if (w_capture_addr) begin
                r_addr_q <= i_pc_in;
            end
            if (w_flush_slots) begin
                r_if_id_valid <= 1'b0;
                r_skid_valid  <= 1'b0;
            end else if (w_load_if_id) begin
                r_if_id_instr <= imem.imem_rdata;
                r_if_id_pc4   <= w_fetch_pc4;
                r_if_id_valid <= 1'b1;
            end else if (w_drain_skid) begin
                r_if_id_instr <= r_skid_instr;
                r_if_id_pc4   <= r_skid_pc4;
                r_if_id_valid <= 1'b1;
                r_skid_valid  <= 1'b0;
            end else if (w_load_skid) begin
                // ID is stalled on the current word; park the new one.
                r_skid_instr <= imem.imem_rdata;
                r_skid_pc4   <= w_fetch_pc4;
                r_skid_valid <= 1'b1;
            end else if (r_if_id_valid && !i_stall_id) begin
                r_if_id_valid <= 1'b0;
            end
        end
    end

    assign o_pc_en        = w_pc_en;
    assign o_pc_next      = w_pc_next;
    assign imem.imem_req  = w_req;
    assign imem.imem_addr = w_addr;
    assign o_if_id_instr  = r_if_id_instr;
    assign o_if_id_pc4    = r_if_id_pc4;
    assign o_if_id_valid  = r_if_id_valid;

endmodule

// File: tb/tb_if_fetch_ctrl.sv
// Bench for if_fetch_ctrl: a directed cycle table for the corner cases,
// then randomized stall/branch/ack-latency traffic checked against a
// program-order model of what ID must receive.
module tb_if_fetch_ctrl;
    localparam logic [31:0] RV = 32'h0000_0100;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] pc_reg = 32'd0;
    logic [31:0] pc_next;
    logic        pc_en;
    logic        br;
    logic [31:0] tgt;
    logic        stall;
    logic [31:0] if_instr;
    logic [31:0] if_pc4;
    logic        if_valid;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    if_fetch_ctrl_if #(.DATA_W(32)) bus ();

    if_fetch_ctrl #(.RESET_VECTOR(RV), .DATA_W(32)) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .i_pc_in         (pc_reg),
        .o_pc_next       (pc_next),
        .o_pc_en         (pc_en),
        .imem            (bus),
        .i_branch_taken  (br),
        .i_branch_target (tgt),
        .i_stall_id      (stall),
        .o_if_id_instr   (if_instr),
        .o_if_id_pc4     (if_pc4),
        .o_if_id_valid   (if_valid)
    );

    // PC register fed by the controller.
    always @(posedge clk) begin
        if (pc_en) pc_reg <= pc_next;
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: actual=%h expected=%h", nm, act, exp);
        end
    endtask

    // Instruction memory contents as a function of address.
    function automatic logic [31:0] memf(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
    endfunction

    typedef struct {
        logic [31:0] rst_n, ack, rdata, stall, br, tgt;
        logic [31:0] en, nx, rq, ad, v, ins, p4;
    } vec_t;

    vec_t vq[$];

    logic        m_busy, m_stale, chk_v0, do_rst, ack;
    logic [31:0] m_addr, exp_pc4, rdata;
    int          m_lat, m_wait, since_rst, consumed;

    initial begin
        rst_n = 1'b0; br = 1'b0; tgt = 32'd0; stall = 1'b0;
        bus.imem_ack = 1'b0; bus.imem_rdata = 32'd0;

        //          rst ack rdata  st br tgt           en nx            rq ad            v ins  p4
        vq.push_back('{0, 0, 0,     0, 0, 0,           0, 0,            0, 0,            0, 0,   0});
        vq.push_back('{1, 0, 0,     0, 0, 0,           1, 'h100,        0, 0,            0, 0,   0});
        vq.push_back('{1, 1, 'hA0,  0, 0, 0,           1, 'h104,        1, 'h100,        0, 0,   0});
        vq.push_back('{1, 1, 'hA1,  0, 0, 0,           1, 'h108,        1, 'h104,        1, 'hA0, 'h104});
        vq.push_back('{1, 1, 'hA2,  0, 0, 0,           1, 'h10C,        1, 'h108,        1, 'hA1, 'h108});
        vq.push_back('{1, 0, 0,     0, 0, 0,           0, 0,            1, 'h10C,        1, 'hA2, 'h10C});
        vq.push_back('{1, 0, 0,     0, 0, 0,           0, 0,            1, 'h10C,        0, 0,   0});
        vq.push_back('{1, 0, 0,     0, 0, 0,           0, 0,            1, 'h10C,        0, 0,   0});
        vq.push_back('{1, 1, 'hA3,  0, 0, 0,           1, 'h110,        1, 'h10C,        0, 0,   0});
        vq.push_back('{1, 1, 'hA4,  1, 0, 0,           1, 'h114,        1, 'h110,        1, 'hA3, 'h110});
        vq.push_back('{1, 0, 0,     1, 0, 0,           0, 0,            0, 0,            1, 'hA3, 'h110});
        vq.push_back('{1, 0, 0,     0, 0, 0,           0, 0,            0, 0,            1, 'hA3, 'h110});
        vq.push_back('{1, 0, 0,     1, 0, 0,           0, 0,            1, 'h114,        1, 'hA4, 'h114});
        vq.push_back('{1, 0, 0,     0, 1, 'h400,       1, 'h400,        1, 'h114,        1, 'hA4, 'h114});
        vq.push_back('{1, 0, 0,     0, 0, 0,           0, 0,            1, 'h114,        0, 0,   0});
        vq.push_back('{1, 1, 'hBAD, 0, 0, 0,           0, 0,            1, 'h114,        0, 0,   0});
        vq.push_back('{1, 1, 'hB0,  0, 0, 0,           1, 'h404,        1, 'h400,        0, 0,   0});
        vq.push_back('{1, 1, 'hBAD, 0, 1, 'h800,       1, 'h800,        1, 'h404,        1, 'hB0, 'h404});
        vq.push_back('{1, 0, 0,     0, 0, 0,           0, 0,            1, 'h800,        0, 0,   0});
        vq.push_back('{1, 1, 'hC0,  0, 0, 0,           1, 'h804,        1, 'h800,        0, 0,   0});
        vq.push_back('{1, 0, 0,     1, 0, 0,           0, 0,            1, 'h804,        1, 'hC0, 'h804});
        vq.push_back('{0, 0, 0,     1, 0, 0,           0, 0,            0, 0,            1, 'hC0, 'h804});
        vq.push_back('{1, 0, 0,     0, 0, 0,           1, 'h100,        0, 0,            0, 0,   0});
        vq.push_back('{1, 0, 0,     0, 1, 'hFFFFFFFC,  1, 'hFFFFFFFC,   1, 'h100,        0, 0,   0});
        vq.push_back('{1, 1, 'hBAD, 0, 0, 0,           0, 0,            1, 'h100,        0, 0,   0});
        vq.push_back('{1, 1, 'hD0,  0, 0, 0,           1, 0,            1, 'hFFFFFFFC,   0, 0,   0});
        vq.push_back('{1, 0, 0,     1, 0, 0,           0, 0,            1, 0,            1, 'hD0, 0});
        vq.push_back('{1, 0, 0,     1, 1, 'h300,       1, 'h300,        1, 0,            1, 'hD0, 0});
        vq.push_back('{1, 0, 0,     0, 1, 'h500,       1, 'h500,        1, 0,            0, 0,   0});
        vq.push_back('{1, 1, 'hBAD, 0, 0, 0,           0, 0,            1, 0,            0, 0,   0});
        vq.push_back('{1, 1, 'hE0,  0, 0, 0,           1, 'h504,        1, 'h500,        0, 0,   0});
        vq.push_back('{1, 1, 'hE1,  1, 0, 0,           1, 'h508,        1, 'h504,        1, 'hE0, 'h504});
        vq.push_back('{0, 0, 0,     1, 0, 0,           0, 0,            0, 0,            1, 'hE0, 'h504});
        vq.push_back('{1, 0, 0,     0, 1, 'h900,       1, 'h100,        0, 0,            0, 0,   0});
        vq.push_back('{1, 0, 0,     0, 0, 0,           0, 0,            1, 'h100,        0, 0,   0});
        vq.push_back('{1, 1, 'hF0,  0, 0, 0,           1, 'h104,        1, 'h100,        0, 0,   0});
        vq.push_back('{1, 1, 'hF1,  1, 0, 0,           1, 'h108,        1, 'h104,        1, 'hF0, 'h104});
        vq.push_back('{1, 0, 0,     1, 1, 'h600,       1, 'h600,        0, 0,            1, 'hF0, 'h104});
        vq.push_back('{1, 0, 0,     0, 0, 0,           0, 0,            1, 'h600,        0, 0,   0});
        vq.push_back('{1, 1, 'h60,  0, 0, 0,           1, 'h604,        1, 'h600,        0, 0,   0});
        vq.push_back('{1, 0, 0,     0, 0, 0,           0, 0,            1, 'h604,        1, 'h60, 'h604});

        repeat (2) @(posedge clk);

        // Directed table: inputs applied after the edge, outputs checked mid-cycle.
        for (int i = 0; i < vq.size(); i++) begin
            @(posedge clk);
            #1;
            rst_n            = vq[i].rst_n[0];
            bus.imem_ack     = vq[i].ack[0];
            bus.imem_rdata   = vq[i].rdata;
            stall            = vq[i].stall[0];
            br               = vq[i].br[0];
            tgt              = vq[i].tgt;
            @(negedge clk);
            chk($sformatf("v%0d_pc_en", i), 32'(pc_en), vq[i].en);
            if (vq[i].en[0]) chk($sformatf("v%0d_pc_next", i), pc_next, vq[i].nx);
            chk($sformatf("v%0d_imem_req", i), 32'(bus.imem_req), vq[i].rq);
            if (vq[i].rq[0]) chk($sformatf("v%0d_imem_addr", i), bus.imem_addr, vq[i].ad);
            chk($sformatf("v%0d_if_id_valid", i), 32'(if_valid), vq[i].v);
            if (vq[i].v[0]) begin
                chk($sformatf("v%0d_if_id_instr", i), if_instr, vq[i].ins);
                chk($sformatf("v%0d_if_id_pc4", i), if_pc4, vq[i].p4);
            end
            $display("vec %0d: pc_en=%0b pc_next=%h req=%0b addr=%h valid=%0b instr=%h pc4=%h",
                     i, pc_en, pc_next, bus.imem_req, bus.imem_addr, if_valid, if_instr, if_pc4);
        end

        // Randomized traffic against a program-order model.
        m_busy = 1'b0; m_stale = 1'b0; chk_v0 = 1'b0; m_addr = 32'd0;
        m_lat = 0; m_wait = 0; since_rst = 0; consumed = 0; exp_pc4 = RV + 32'd4;
        for (int c = 0; c < 2000; c++) begin
            @(posedge clk);
            #1;
            do_rst = (c < 2) || ($urandom_range(0, 399) == 0);
            rst_n  = !do_rst;
            stall  = ($urandom_range(0, 9) < 3);
            tgt    = $urandom & 32'hFFFF_FFFC;
            if ($urandom_range(0, 7) == 0) tgt = 32'hFFFF_FFFC;
            br     = !do_rst && (since_rst >= 1) && ($urandom_range(0, 14) == 0);
            #1;
            ack   = 1'b0;
            rdata = $urandom;
            if (do_rst) begin
                m_busy  = 1'b0;
                m_stale = 1'b0;
            end else begin
                if (m_busy) begin
                    chk("req_held", 32'(bus.imem_req), 32'd1);
                    chk("addr_held", bus.imem_addr, m_addr);
                end
                if (bus.imem_req) begin
                    if (!m_busy) begin
                        m_busy = 1'b1;
                        m_addr = bus.imem_addr;
                        m_lat  = $urandom_range(0, 3);
                        m_wait = 0;
                    end
                    if (m_wait >= m_lat) begin
                        ack   = 1'b1;
                        rdata = memf(m_addr);
                    end else begin
                        m_wait++;
                    end
                end
            end
            bus.imem_ack   = ack;
            bus.imem_rdata = rdata;
            @(negedge clk);
            if (do_rst) begin
                chk("rst_req", 32'(bus.imem_req), 32'd0);
                chk("rst_pc_en", 32'(pc_en), 32'd0);
            end else if (since_rst == 0) begin
                chk("init_pc_en", 32'(pc_en), 32'd1);
                chk("init_pc_next", pc_next, RV);
                chk("init_req", 32'(bus.imem_req), 32'd0);
                chk("init_valid", 32'(if_valid), 32'd0);
            end else begin
                if (br) begin
                    chk("br_pc_en", 32'(pc_en), 32'd1);
                    chk("br_pc_next", pc_next, tgt);
                end else if (ack) begin
                    chk("ack_pc_en", 32'(pc_en), 32'(!m_stale));
                    if (!m_stale) chk("ack_pc_next", pc_next, m_addr + 32'd4);
                end else begin
                    chk("idle_pc_en", 32'(pc_en), 32'd0);
                end
                if (chk_v0) chk("valid_after_br", 32'(if_valid), 32'd0);
                if (if_valid && !stall) begin
                    consumed++;
                    chk("deliv_pc4", if_pc4, exp_pc4);
                    chk("deliv_instr", if_instr, memf(if_pc4 - 32'd4));
                    $display("txn %0d: instr=%h pc4=%h", consumed, if_instr, if_pc4);
                    exp_pc4 = if_pc4 + 32'd4;
                end
            end
            chk_v0 = br;
            if (ack) begin
                m_busy  = 1'b0;
                m_stale = 1'b0;
            end else if (br && m_busy) begin
                m_stale = 1'b1;
            end
            if (do_rst) begin
                since_rst = 0;
                exp_pc4   = RV + 32'd4;
            end else begin
                since_rst++;
            end
            if (br) exp_pc4 = tgt + 32'd4;
        end
        chk("liveness", 32'(consumed >= 200), 32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
